as_qspi: RTL and testbench

Wishbone slave SPI/QSPI master controller filling the QSPI slot of the data-bus memory map at 64'h0001_0010–64'h0001_001F (chip-select bit csx[2]). The CPU programs a divider, TX word and control word over the data bus, and the block shifts up to 8 bytes MSB-first to an external flash/peripheral in single-lane full-duplex or quad-lane half-duplex mode. It drives the QSPI read-data mux input and the QSPI ack term of the combined bus acknowledge.

---
 rtl/as_pack.sv | 28 ++
 rtl/as_qspi_shift.sv | 153 +++++++++++++++
 rtl/as_qspi.sv | 108 ++++++++++
 tb/tb_as_qspi.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// Shared constants, register map and types for the QSPI master slot.
package as_pack;

    localparam int unsigned qspi_addr_width = 4;
    localparam int unsigned data_width      = 64;

    localparam logic [qspi_addr_width-1:0] REG_CTRL   = 4'd0;
    localparam logic [qspi_addr_width-1:0] REG_DIV    = 4'd1;
    localparam logic [qspi_addr_width-1:0] REG_TX     = 4'd2;
    localparam logic [qspi_addr_width-1:0] REG_RX     = 4'd3;
    localparam logic [qspi_addr_width-1:0] REG_STATUS = 4'd4;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_QUAD   = 1;
    localparam int unsigned CTRL_DIR    = 2;
    localparam int unsigned CTRL_HOLD   = 3;
    localparam int unsigned CTRL_NB_LSB = 4;

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_END} qspi_state_t;

    typedef struct packed {
        logic       quad;
        logic       dir;
        logic       hold;
        logic [2:0] nb;
    } qspi_cfg_t;

endpackage

// File: rtl/as_qspi_shift.sv
// SCK divider plus shift/sample engine; one transfer of 1..8 bytes per start pulse.
module as_qspi_shift
    import as_pack::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             release_i,
    input  qspi_cfg_t        cfg_i,
    input  logic [7:0]       div_i,
    input  logic [63:0]      tx_i,
    input  logic [3:0]       dat_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [63:0]      rx_o,
    output logic             sck_o,
    output logic             cs_n_o,
    output logic [3:0]       dat_o,
    output logic [3:0]       oe_o
);

    qspi_state_t state_q, state_d;
    qspi_cfg_t   cfg_q, cfg_d;
    logic [7:0]  hc_q, hc_d;
    logic        ph_q, ph_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] sh_q, sh_d;
    logic [63:0] rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic [3:0]  nbytes;
    logic        hc_end;

    assign nbytes = {1'b0, cfg_i.nb} + 4'd1;
    assign hc_end = (hc_q == div_i);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        hc_d    = hc_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CS_SETUP;
                    cfg_d   = cfg_i;
                    // Left-align the N-byte payload so the first bit is always sh[63].
                    sh_d    = tx_i << {~cfg_i.nb, 3'b000};
                    rx_d    = '0;
                    cnt_d   = cfg_i.quad ? {2'b00, nbytes, 1'b0} : {nbytes, 3'b000};
                    hc_d    = '0;
                    ph_d    = 1'b0;
                    sck_d   = 1'b0;
                    cs_n_d  = 1'b0;
                end else if (release_i) begin
                    cs_n_d = 1'b1;
                end
            end
            CS_SETUP: begin
                if (hc_end) begin
                    hc_d    = '0;
                    ph_d    = 1'b0;
                    state_d = SHIFT;
                end else begin
                    hc_d = hc_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!hc_end) begin
                    hc_d = hc_q + 8'd1;
                end else begin
                    hc_d = '0;
                    if (!ph_q) begin
                        ph_d  = 1'b1;
                        sck_d = 1'b1;
                        if (!cfg_q.quad)
                            rx_d = {rx_q[62:0], dat_i[1]};
                        else if (cfg_q.dir)
                            rx_d = {rx_q[59:0], dat_i};
                    end else begin
                        ph_d  = 1'b0;
                        sck_d = 1'b0;
                        sh_d  = cfg_q.quad ? (sh_q << 4) : (sh_q << 1);
                        cnt_d = cnt_q - 7'd1;
                        if (cnt_q == 7'd1)
                            state_d = CS_END;
                    end
                end
            end
            CS_END: begin
                if (hc_end) begin
                    hc_d    = '0;
                    state_d = IDLE;
                    done_o  = 1'b1;
                    cs_n_d  = ~cfg_q.hold;
                end else begin
                    hc_d = hc_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            hc_q    <= '0;
            ph_q    <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            hc_q    <= hc_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        dat_o = '0;
        oe_o  = '0;
        if (state_q != IDLE) begin
            if (!cfg_q.quad) begin
                dat_o = {3'b000, sh_q[63]};
                oe_o  = 4'b0001;
            end else if (!cfg_q.dir) begin
                dat_o = sh_q[63:60];
                oe_o  = 4'b1111;
            end
        end
    end

    assign busy_o = (state_q != IDLE);
    assign rx_o   = rx_q;
    assign sck_o  = sck_q;
    assign cs_n_o = cs_n_q;

endmodule

// File: rtl/as_qspi.sv
// Wishbone register file for the QSPI slot; wraps the shift engine.
module as_qspi
    import as_pack::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [qspi_addr_width-1:0] wbdAddr_i,
    input  logic [data_width-1:0]      wbdDat_i,
    output logic [data_width-1:0]      wbdDat_o,
    input  logic                       wbdWe_i,
    input  logic [7:0]                 wbdSel_i,
    input  logic                       wbdStb_i,
    input  logic                       wbdCyc_i,
    output logic                       wbdAck_o,
    output logic                       qspi_sck_o,
    output logic                       qspi_cs_n_o,
    output logic [3:0]                 qspi_dat_o,
    output logic [3:0]                 qspi_oe_o,
    input  logic [3:0]                 qspi_dat_i
);

    logic [6:1]            ctrl_q;
    logic [7:0]            div_q;
    logic [data_width-1:0] tx_q;
    logic                  done_q;
    logic                  ack_q;
    logic [data_width-1:0] rdat_q;
    logic [data_width-1:0] rd_val;
    logic [data_width-1:0] rx;
    logic                  acc, wr, ctrl_wr, start, rel, busy, done_p;
    qspi_cfg_t             cfg;

    assign acc     = wbdStb_i & wbdCyc_i & ~ack_q;
    assign wr      = acc & wbdWe_i;
    assign ctrl_wr = wr & (wbdAddr_i == REG_CTRL) & wbdSel_i[0] & ~busy;
    assign start   = ctrl_wr & wbdDat_i[CTRL_START];
    assign rel     = ctrl_wr & ~wbdDat_i[CTRL_HOLD];

    always_comb begin
        cfg.quad = wbdDat_i[CTRL_QUAD];
        cfg.dir  = wbdDat_i[CTRL_DIR];
        cfg.hold = wbdDat_i[CTRL_HOLD];
        cfg.nb   = wbdDat_i[CTRL_NB_LSB +: 3];
    end

    always_comb begin
        rd_val = '0;
        case (wbdAddr_i)
            REG_CTRL:   rd_val[6:1] = ctrl_q;
            REG_DIV:    rd_val[7:0] = div_q;
            REG_TX:     rd_val      = tx_q;
            REG_RX:     rd_val      = rx;
            REG_STATUS: rd_val[1:0] = {done_q, busy};
            default:    rd_val      = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            div_q  <= '0;
            tx_q   <= '0;
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q  <= acc;
            rdat_q <= (acc & ~wbdWe_i) ? rd_val : '0;
            if (ctrl_wr)
                ctrl_q <= wbdDat_i[6:1];
            if (wr && (wbdAddr_i == REG_DIV) && wbdSel_i[0] && !busy)
                div_q <= wbdDat_i[7:0];
            if (wr && (wbdAddr_i == REG_TX) && !busy) begin
                for (int unsigned b = 0; b < 8; b++)
                    if (wbdSel_i[b])
                        tx_q[b*8 +: 8] <= wbdDat_i[b*8 +: 8];
            end
            if (start)
                done_q <= 1'b0;
            else if (done_p)
                done_q <= 1'b1;
            else if (wr && (wbdAddr_i == REG_STATUS) && wbdSel_i[0] && wbdDat_i[1])
                done_q <= 1'b0;
        end
    end

    as_qspi_shift u_shift (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start),
        .release_i (rel),
        .cfg_i     (cfg),
        .div_i     (div_q),
        .tx_i      (tx_q),
        .dat_i     (qspi_dat_i),
        .busy_o    (busy),
        .done_o    (done_p),
        .rx_o      (rx),
        .sck_o     (qspi_sck_o),
        .cs_n_o    (qspi_cs_n_o),
        .dat_o     (qspi_dat_o),
        .oe_o      (qspi_oe_o)
    );

    assign wbdDat_o = rdat_q;
    assign wbdAck_o = ack_q;

endmodule

// File: tb/tb_as_qspi.sv
// Self-checking bench for as_qspi: cycle-exact pin model plus register/RX checks.
module tb_as_qspi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wb_addr = '0;
    logic [63:0] wb_wdat = '0;
    logic [63:0] wb_rdat;
    logic        wb_we = 1'b0;
    logic [7:0]  wb_sel = '0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic        sck, cs_n;
    logic [3:0]  sdo, oe;
    logic [3:0]  sdi = '0;

    as_qspi dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wbdAddr_i   (wb_addr),
        .wbdDat_i    (wb_wdat),
        .wbdDat_o    (wb_rdat),
        .wbdWe_i     (wb_we),
        .wbdSel_i    (wb_sel),
        .wbdStb_i    (wb_stb),
        .wbdCyc_i    (wb_cyc),
        .wbdAck_o    (wb_ack),
        .qspi_sck_o  (sck),
        .qspi_cs_n_o (cs_n),
        .qspi_dat_o  (sdo),
        .qspi_oe_o   (oe),
        .qspi_dat_i  (sdi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned edge_cnt = 0;
    logic [3:0] din [0:65535];
    bit         din_fixed = 1'b0;
    logic [3:0] din_val = '0;
    logic [3:0] din_next;

    // transfer model: pending (p_*) copied to active (m_*) when the start write is issued
    bit          xfer_on = 1'b0;
    bit          idle_cs_low = 1'b0;
    int unsigned m_e0, m_H, m_C, m_N;
    bit          m_quad, m_dir, m_hold;
    logic [63:0] m_tx;
    int unsigned p_H, p_C, p_N;
    bit          p_quad, p_dir, p_hold;
    logic [63:0] p_tx;
    logic [3:0]  obs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        din_next = din_fixed ? din_val : 4'($urandom);
        sdi = din_next;
        din[(edge_cnt + 1) & 32'hFFFF] = din_next;
    end

    initial begin : compare
        int unsigned k, total, p, m;
        logic       e_sck, e_cs_n;
        logic [3:0] e_dat, e_oe;
        logic       prev_sck;
        prev_sck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            e_sck = 1'b0; e_dat = '0; e_oe = '0;
            total = m_H * (2 * m_C + 2);
            k = edge_cnt - m_e0;
            if (xfer_on && k < total) begin
                e_cs_n = 1'b0;
                if (k < m_H) begin
                    p = 0;
                end else if (k < m_H + 2 * m_C * m_H) begin
                    m = k - m_H;
                    p = m / (2 * m_H);
                    e_sck = (m % (2 * m_H)) >= m_H;
                end else begin
                    p = m_C;
                end
                e_oe = m_quad ? (m_dir ? 4'h0 : 4'hF) : 4'h1;
                if (p < m_C) begin
                    if (!m_quad)
                        e_dat = {3'b000, m_tx[8 * m_N - 1 - p]};
                    else if (!m_dir)
                        e_dat = 4'(m_tx >> (8 * m_N - 4 - 4 * p));
                end
            end else begin
                e_cs_n = (xfer_on ? m_hold : idle_cs_low) ? 1'b0 : 1'b1;
            end
            chk("sck", {63'b0, sck}, {63'b0, e_sck});
            chk("cs_n", {63'b0, cs_n}, {63'b0, e_cs_n});
            chk("dat_o", {60'b0, sdo}, {60'b0, e_dat});
            chk("oe", {60'b0, oe}, {60'b0, e_oe});
            if (!prev_sck && sck) obs.push_back(sdo);
            prev_sck = sck;
        end
    end

    // mode: 0 plain access, 1 arms the transfer model, 2 models a cs release
    task automatic wb_access(input bit we, input logic [3:0] addr, input logic [63:0] data,
                             input logic [7:0] sel, input int mode, output logic [63:0] rdata);
        @(negedge clk);
        wb_we = we; wb_addr = addr; wb_wdat = data; wb_sel = sel;
        wb_stb = 1'b1; wb_cyc = 1'b1;
        if (mode == 1) begin
            m_H = p_H; m_C = p_C; m_N = p_N; m_quad = p_quad; m_dir = p_dir;
            m_hold = p_hold; m_tx = p_tx; m_e0 = edge_cnt + 1; xfer_on = 1'b1;
            obs.delete();
        end else if (mode == 2) begin
            xfer_on = 1'b0; idle_cs_low = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ack_rise", {63'b0, wb_ack}, 64'h1);
        rdata = wb_rdat;
        @(negedge clk);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_fall", {63'b0, wb_ack}, 64'h0);
    endtask

    task automatic do_xfer(input logic [7:0] div, input logic [2:0] nb, input bit quad, dir, hold,
                           input logic [63:0] tx, input bit poke, output logic [63:0] rx);
        logic [63:0] rd, erx;
        logic [3:0]  v;
        int unsigned total, j;
        wb_access(1'b1, 4'd1, {56'b0, div}, 8'hFF, 0, rd);
        wb_access(1'b1, 4'd2, tx, 8'hFF, 0, rd);
        p_H = div + 1; p_N = nb + 1; p_C = quad ? 2 * p_N : 8 * p_N;
        p_quad = quad; p_dir = dir; p_hold = hold; p_tx = tx;
        wb_access(1'b1, 4'd0, {57'b0, nb, hold, dir, quad, 1'b1}, 8'h01, 1, rd);
        total = m_H * (2 * m_C + 2);
        wb_access(1'b0, 4'd4, '0, '0, 0, rd);
        chk("status_busy", rd, 64'h1);
        if (poke) begin
            wb_access(1'b1, 4'd2, ~tx, 8'hFF, 0, rd);
            wb_access(1'b1, 4'd1, 64'hFF, 8'hFF, 0, rd);
            wb_access(1'b1, 4'd0, 64'h73, 8'hFF, 0, rd);
        end
        while (edge_cnt + 1 < m_e0 + total) begin
            @(posedge clk);
            #1;
        end
        wb_access(1'b0, 4'd4, '0, '0, 0, rd);
        chk("status_last_busy", rd, 64'h1);
        wb_access(1'b0, 4'd4, '0, '0, 0, rd);
        chk("status_done", rd, 64'h2);
        erx = '0;
        for (int unsigned q = 0; q < m_C; q++) begin
            j = m_e0 + 2 * m_H * (q + 1);
            v = din[j & 32'hFFFF];
            if (!quad) erx = {erx[62:0], v[1]};
            else if (dir) erx = {erx[59:0], v};
        end
        wb_access(1'b0, 4'd3, '0, '0, 0, rd);
        rx = rd;
        chk("rxdata", rd, erx);
        if (poke) begin
            wb_access(1'b0, 4'd2, '0, '0, 0, rd);
            chk("tx_busy_ignored", rd, tx);
            wb_access(1'b0, 4'd1, '0, '0, 0, rd);
            chk("div_busy_ignored", rd, {56'b0, div});
            wb_access(1'b0, 4'd0, '0, '0, 0, rd);
            chk("ctrl_busy_ignored", rd, {57'b0, nb, hold, dir, quad, 1'b0});
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] rd, rx;
        int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int qw_nib[4]  = '{1, 2, 3, 4};
        logic [3:0] offs[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_ack", {63'b0, wb_ack}, 64'h0);
        chk("rst_rdat", wb_rdat, 64'h0);
        foreach (offs[i]) begin
            wb_access(1'b0, offs[i], '0, '0, 0, rd);
            chk("rst_read", rd, 64'h0);
        end

        // single lane, 0xA5, MISO held high
        din_fixed = 1'b1; din_val = 4'b0010;
        do_xfer(8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 64'hA5, 1'b0, rx);
        chk("a5_rx", rx, 64'hFF);
        chk("a5_busy_len", 64'(m_H * (2 * m_C + 2)), 64'd36);
        chk("a5_nbits", 64'(obs.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < obs.size()) chk("a5_mosi", {60'b0, obs[i]}, 64'(a5_bits[i]));

        // quad write 0x1234
        din_fixed = 1'b0;
        do_xfer(8'd0, 3'd1, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b0, rx);
        chk("qw_nnib", 64'(obs.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < obs.size()) chk("qw_nib", {60'b0, obs[i]}, 64'(qw_nib[i]));

        // quad read with constant 0xC on the lanes
        din_fixed = 1'b1; din_val = 4'hC;
        do_xfer(8'd0, 3'd0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, rx);
        chk("qr_rx", rx, 64'hCC);

        wb_access(1'b1, 4'd4, 64'h2, 8'h01, 0, rd);
        wb_access(1'b0, 4'd4, '0, '0, 0, rd);
        chk("done_clear", rd, 64'h0);

        // cs_hold pair, with ignored writes during the second transfer
        din_fixed = 1'b0;
        do_xfer(8'd1, 3'd0, 1'b0, 1'b0, 1'b1, 64'h3C, 1'b0, rx);
        chk("hold_cs_low", {63'b0, cs_n}, 64'h0);
        do_xfer(8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h5A, 1'b1, rx);
        chk("hold_cs_released", {63'b0, cs_n}, 64'h1);

        for (int t = 0; t < 12; t++) begin
            do_xfer(8'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
                    1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'b0, rx);
        end
        wb_access(1'b1, 4'd0, 64'h0, 8'h01, 2, rd);

        // reset in the middle of SHIFT
        p_H = 3; p_N = 4; p_C = 32; p_quad = 1'b0; p_dir = 1'b0; p_hold = 1'b0;
        p_tx = 64'hDEAD_BEEF;
        wb_access(1'b1, 4'd1, 64'h2, 8'hFF, 0, rd);
        wb_access(1'b1, 4'd2, p_tx, 8'hFF, 0, rd);
        wb_access(1'b1, 4'd0, 64'h31, 8'h01, 1, rd);
        while (edge_cnt < m_e0 + 20) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1; xfer_on = 1'b0; idle_cs_low = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_cs_n", {63'b0, cs_n}, 64'h1);
        chk("rst_mid_sck", {63'b0, sck}, 64'h0);
        @(negedge clk) rst = 1'b0;
        wb_access(1'b0, 4'd4, '0, '0, 0, rd);
        chk("rst_mid_status", rd, 64'h0);
        wb_access(1'b0, 4'd3, '0, '0, 0, rd);
        chk("rst_mid_rx", rd, 64'h0);
        wb_access(1'b0, 4'd2, '0, '0, 0, rd);
        chk("rst_mid_tx", rd, 64'h0);
        wb_access(1'b0, 4'd1, '0, '0, 0, rd);
        chk("rst_mid_div", rd, 64'h0);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
